updn_counter_param: RTL and testbench

//   Parametrised up/down counter with programmable limits, selectable

---
 rtl/updn_counter_param_pkg.sv | 15 +
 rtl/updn_counter_param_next_calc.sv | 93 +++++++++
 rtl/updn_counter_param.sv | 89 ++++++++
 tb/tb_updn_counter_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/updn_counter_param_pkg.sv
// Shared encodings for the parametrised up/down counter: wrap/saturate modes
// and the per-cycle operation select (load > down > up > hold).
package updn_counter_param_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_DOWN = 2'd2,
    SEL_UP   = 2'd3
  } sel_e;

endpackage

// File: rtl/updn_counter_param_next_calc.sv
// Combinational next-count for the up/down counter: operation select, clamping
// into the limit window, step arithmetic with borrow/overflow and event decode.
module updn_counter_param_next_calc
  import updn_counter_param_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int STEPW = 3
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic [STEPW-1:0] step_i,
  input  logic             wrap_mode_i,
  input  logic [WIDTH-1:0] lim_lo_i,
  input  logic [WIDTH-1:0] lim_hi_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_up_o,
  output logic             tc_dn_o,
  output logic             ovf_o,
  output logic             udf_o,
  output logic             cfg_err_o
);

  localparam int XW = WIDTH + 1;

  logic [XW-1:0]    lo_x, hi_x, step_x, base_x, sum_x, diff_x;
  logic [WIDTH-1:0] ld_clamp;
  logic             wrap;
  sel_e             sel;

  always_comb begin
    lo_x      = XW'(lim_lo_i);
    hi_x      = XW'(lim_hi_i);
    step_x    = XW'(step_i);
    cfg_err_o = (lim_lo_i > lim_hi_i);
    wrap      = (wrap_mode_i == MODE_WRAP);

    // A count left outside the window by a live limit change is pulled back first.
    if (count_i < lim_lo_i)      base_x = lo_x;
    else if (count_i > lim_hi_i) base_x = hi_x;
    else                         base_x = XW'(count_i);

    if (load_val_i < lim_lo_i)      ld_clamp = lim_lo_i;
    else if (load_val_i > lim_hi_i) ld_clamp = lim_hi_i;
    else                            ld_clamp = load_val_i;

    sum_x  = base_x + step_x;
    diff_x = base_x - step_x;

    sel = SEL_HOLD;
    if (!cfg_err_o) begin
      if (load_i)                                    sel = SEL_LOAD;
      else if (en_i && down_i && (step_i != '0))     sel = SEL_DOWN;
      else if (en_i && up_i && !down_i && (step_i != '0)) sel = SEL_UP;
    end

    count_o = count_i;
    tc_up_o = 1'b0;
    tc_dn_o = 1'b0;
    ovf_o   = 1'b0;
    udf_o   = 1'b0;

    case (sel)
      SEL_LOAD: count_o = ld_clamp;
      SEL_DOWN: begin
        // The extra top bit of diff_x is the borrow out of the subtraction.
        if (diff_x[WIDTH] || (diff_x < lo_x)) begin
          udf_o   = 1'b1;
          tc_dn_o = 1'b1;
          count_o = wrap ? lim_hi_i : lim_lo_i;
        end else begin
          count_o = diff_x[WIDTH-1:0];
          tc_dn_o = (diff_x == lo_x);
        end
      end
      SEL_UP: begin
        if (sum_x > hi_x) begin
          ovf_o   = 1'b1;
          tc_up_o = 1'b1;
          count_o = wrap ? lim_lo_i : lim_hi_i;
        end else begin
          count_o = sum_x[WIDTH-1:0];
          tc_up_o = (sum_x == hi_x);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with programmable limits, saturate/wrap mode,
// variable step, registered terminal-count pulses and sticky ovf/udf flags.
module updn_counter_param
  import updn_counter_param_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter int               STEPW   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  input  logic [STEPW-1:0] step,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] lim_lo,
  input  logic [WIDTH-1:0] lim_hi,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             high,
  output logic             low,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             ovf,
  output logic             udf,
  output logic             cfg_err
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_up_q, tc_up_d, tc_dn_q, tc_dn_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             ovf_evt, udf_evt;

  updn_counter_param_next_calc #(
    .WIDTH (WIDTH),
    .STEPW (STEPW)
  ) u_next (
    .count_i     (count_q),
    .load_i      (load),
    .load_val_i  (load_val),
    .en_i        (en),
    .up_i        (up),
    .down_i      (down),
    .step_i      (step),
    .wrap_mode_i (wrap_mode),
    .lim_lo_i    (lim_lo),
    .lim_hi_i    (lim_hi),
    .count_o     (count_d),
    .tc_up_o     (tc_up_d),
    .tc_dn_o     (tc_dn_d),
    .ovf_o       (ovf_evt),
    .udf_o       (udf_evt),
    .cfg_err_o   (cfg_err)
  );

  // A new event in the same cycle as clr_flags keeps the flag set.
  always_comb begin
    ovf_d = ovf_evt | (ovf_q & ~clr_flags);
    udf_d = udf_evt | (udf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
      tc_up_q <= 1'b0;
      tc_dn_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_up_q <= tc_up_d;
      tc_dn_q <= tc_dn_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count = count_q;
  assign high  = (count_q == lim_hi);
  assign low   = (count_q == lim_lo);
  assign tc_up = tc_up_q;
  assign tc_dn = tc_dn_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_updn_counter_param.sv
// Bench for updn_counter_param: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an integer model.
module tb_updn_counter_param;

  logic       clk, rst_n;
  logic       en, load, up, down, wrap_mode, clr_flags;
  logic [4:0] load_val, lim_lo, lim_hi, count;
  logic [2:0] step;
  logic       high, low, tc_up, tc_dn, ovf, udf, cfg_err;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  int m_count;
  bit m_tcu, m_tcd, m_ovf, m_udf;

  updn_counter_param #(.WIDTH(5), .STEPW(3), .RST_VAL(5'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .up        (up),
    .down      (down),
    .step      (step),
    .wrap_mode (wrap_mode),
    .lim_lo    (lim_lo),
    .lim_hi    (lim_hi),
    .clr_flags (clr_flags),
    .count     (count),
    .high      (high),
    .low       (low),
    .tc_up     (tc_up),
    .tc_dn     (tc_dn),
    .ovf       (ovf),
    .udf       (udf),
    .cfg_err   (cfg_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clampv(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference behaviour expressed directly in integer arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_tcu = 0; m_tcd = 0; m_ovf = 0; m_udf = 0;
    end else begin
      int lo, hi, c, s, b, r;
      bit tu, td, ov, ud;
      lo = lim_lo; hi = lim_hi; c = m_count; s = step;
      tu = 0; td = 0; ov = 0; ud = 0;
      if (lo <= hi) begin
        if (load) c = clampv(load_val, lo, hi);
        else if (en && (up || down) && s != 0) begin
          b = clampv(c, lo, hi);
          if (down) begin
            r = b - s;
            td = (r <= lo);
            if (r < lo) begin ud = 1; c = wrap_mode ? hi : lo; end
            else c = r;
          end else begin
            r = b + s;
            tu = (r >= hi);
            if (r > hi) begin ov = 1; c = wrap_mode ? lo : hi; end
            else c = r;
          end
        end
      end
      m_count = c; m_tcu = tu; m_tcd = td;
      m_ovf = ov || (m_ovf && !clr_flags);
      m_udf = ud || (m_udf && !clr_flags);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_count",   count,   m_count);
      check("cmp_high",    high,    (m_count == lim_hi));
      check("cmp_low",     low,     (m_count == lim_lo));
      check("cmp_tc_up",   tc_up,   m_tcu);
      check("cmp_tc_dn",   tc_dn,   m_tcd);
      check("cmp_ovf",     ovf,     m_ovf);
      check("cmp_udf",     udf,     m_udf);
      check("cmp_cfg_err", cfg_err, (lim_lo > lim_hi));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; up = 0; down = 0; wrap_mode = 0; clr_flags = 0;
    load_val = 0; step = 0; lim_lo = 0; lim_hi = 31;
    cyc(2);
    rst_n = 1;
    chk_en = 1;
    check("reset_count", count, 0);

    // async reset mid-count
    load = 1; load_val = 17;
    cyc();
    load = 0;
    check("t1_load17", count, 17);
    #2 rst_n = 0;
    #1;
    check("t1_rst_count", count, 0);
    check("t1_rst_flags", {tc_up, tc_dn, ovf, udf}, 0);
    @(posedge clk); #1 rst_n = 1;

    // load beats up, down beats up
    load = 1; up = 1; en = 1; step = 1; load_val = 15;
    cyc();
    check("t2_load", count, 15);
    load = 0; down = 1;
    cyc();
    check("t2_dn1", count, 14);
    cyc();
    check("t2_dn2", count, 13);
    up = 0; down = 0;

    // saturating down to lim_lo and past it
    wrap_mode = 0; load = 1; load_val = 2;
    cyc();
    load = 0; down = 1;
    cyc();
    check("t3_c1", count, 1);
    check("t3_tcdn0", tc_dn, 0);
    cyc();
    check("t3_c0", count, 0);
    check("t3_tcdn", tc_dn, 1);
    check("t3_low", low, 1);
    check("t3_noudf", udf, 0);
    cyc();
    check("t3_hold", count, 0);
    check("t3_udf", udf, 1);
    check("t3_tcdn_again", tc_dn, 1);
    down = 0;
    cyc();
    check("t3_tc_end", tc_dn, 0);
    check("t3_sticky", udf, 1);
    clr_flags = 1;
    cyc();
    clr_flags = 0;
    check("t3_clr", udf, 0);

    // wrap overflow in 4..20
    lim_lo = 4; lim_hi = 20; wrap_mode = 1; load = 1; load_val = 18;
    cyc();
    load = 0;
    check("t4_load", count, 18);
    up = 1; step = 3;
    cyc();
    up = 0;
    check("t4_wrap", count, 4);
    check("t4_tcup", tc_up, 1);
    check("t4_ovf", ovf, 1);
    clr_flags = 1;
    cyc();
    clr_flags = 0;
    check("t4_clr", ovf, 0);

    // load clamped to lim_hi
    lim_lo = 0; lim_hi = 20; load = 1; load_val = 31;
    cyc();
    load = 0;
    check("t5_clamp", count, 20);
    check("t5_high", high, 1);
    check("t5_notc", tc_up, 0);

    // inverted limits freeze the counter
    lim_lo = 10; lim_hi = 5;
    #1;
    check("t6_cfg_err", cfg_err, 1);
    load = 1; load_val = 7; up = 1; en = 1; step = 1;
    cyc();
    check("t6_ld_ign", count, 20);
    load = 0;
    cyc();
    check("t6_up_ign", count, 20);
    check("t6_no_tc", tc_up, 0);
    lim_lo = 0; lim_hi = 31; en = 0;
    cyc();
    check("t6_en0", count, 20);
    en = 1; step = 0;
    cyc();
    check("t6_step0", count, 20);
    check("t6_step0_tc", tc_up, 0);
    up = 0;

    // live limit shrink: clamp to 10 then down by 2, no udf
    lim_hi = 10; down = 1; step = 2; wrap_mode = 0;
    cyc();
    down = 0;
    check("t7_clamp_dn", count, 8);
    check("t7_no_udf", udf, 0);

    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(0, 15) == 0);
      load_val  = 5'($urandom_range(0, 31));
      en        = ($urandom_range(0, 3) != 0);
      up        = $urandom_range(0, 1);
      down      = $urandom_range(0, 1);
      step      = 3'($urandom_range(0, 7));
      wrap_mode = $urandom_range(0, 1);
      clr_flags = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        int a, b;
        a = $urandom_range(0, 31);
        b = $urandom_range(0, 31);
        if (a > b && $urandom_range(0, 7) != 0) begin
          lim_lo = 5'(b); lim_hi = 5'(a);
        end else begin
          lim_lo = 5'(a); lim_hi = 5'(b);
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
      cyc();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
